// File: rtl/memtest_datagen_if.sv
// rtl/memtest_datagen_if.sv - seed/size inputs and Avalon-ST pattern stream of the memtest data generator
interface memtest_datagen_if #(
    parameter int SIZE_W = 32
);
    logic              asi_seed_valid;
    logic [127:0]      asi_seed_data;
    logic              asi_size_valid;
    logic [SIZE_W-1:0] asi_size_data;
    logic              aso_data_valid;
    logic              aso_data_ready;
    logic [127:0]      aso_data_data;
    logic              aso_data_startofpacket;
    logic              aso_data_endofpacket;
    logic [3:0]        aso_pktstatus_data;

    modport master (
        input  asi_seed_valid, asi_seed_data, asi_size_valid, asi_size_data, aso_data_ready,
        output aso_data_valid, aso_data_data, aso_data_startofpacket, aso_data_endofpacket,
               aso_pktstatus_data
    );

    modport slave (
        output asi_seed_valid, asi_seed_data, asi_size_valid, asi_size_data, aso_data_ready,
        input  aso_data_valid, aso_data_data, aso_data_startofpacket, aso_data_endofpacket,
               aso_pktstatus_data
    );
endinterface

// File: rtl/memtest_datagen.sv
// rtl/memtest_datagen.sv - four-lane LFSR pattern generator emitting fixed-length 128-bit packets
module memtest_datagen #(
    parameter int SIZE_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    memtest_datagen_if.master  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [127:0]      pat_q, pat_d;
    logic [SIZE_W-1:0] rem_q, rem_d;
    logic              sop_q, sop_d;
    logic [3:0]        status_q, status_d;
    logic              xfer;

    // Each lane shifts left independently; an all-zero lane stays at zero.
    function automatic logic [127:0] advance(input logic [127:0] p);
        logic [127:0] r;
        logic [31:0]  l;
        r = '0;
        for (int n = 0; n < 4; n++) begin
            l = p[32*n +: 32];
            r[32*n +: 32] = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            rem_q    <= '0;
            sop_q    <= 1'b0;
            status_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            rem_q    <= rem_d;
            sop_q    <= sop_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        rem_d    = rem_q;
        sop_d    = sop_q;
        status_d = status_q;
        xfer     = (state_q == RUN) && bus.aso_data_ready;
        case (state_q)
            IDLE: begin
                if (bus.asi_seed_valid) begin
                    pat_d = bus.asi_seed_data;
                end
                if (bus.asi_size_valid) begin
                    if (bus.asi_size_data != '0) begin
                        state_d  = RUN;
                        rem_d    = bus.asi_size_data;
                        sop_d    = 1'b1;
                        status_d = 4'b0001;
                    end else begin
                        status_d[2] = 1'b1;
                        status_d[1] = 1'b0;
                    end
                end
            end
            RUN: begin
                if (bus.asi_size_valid) begin
                    status_d[3] = 1'b1;
                end
                // Seed is honoured only on a transfer so the presented beat never changes under stall.
                if (xfer) begin
                    pat_d = bus.asi_seed_valid ? bus.asi_seed_data : advance(pat_q);
                    sop_d = 1'b0;
                    rem_d = rem_q - SIZE_W'(1);
                    if (rem_q == SIZE_W'(1)) begin
                        state_d     = IDLE;
                        status_d[1] = 1'b1;
                        status_d[0] = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.aso_data_valid         = (state_q == RUN);
        bus.aso_data_data          = pat_q;
        bus.aso_data_startofpacket = (state_q == RUN) && sop_q;
        bus.aso_data_endofpacket   = (state_q == RUN) && (rem_q == SIZE_W'(1));
        bus.aso_pktstatus_data     = status_q;
    end
endmodule

// File: tb/tb_memtest_datagen.sv
// tb/tb_memtest_datagen.sv - randomized and directed checks of memtest_datagen against a packet-level model
module tb_memtest_datagen;
    localparam int SIZE_W = 8;

    logic clk;
    logic reset;

    memtest_datagen_if #(.SIZE_W(SIZE_W)) bus();

    memtest_datagen #(.SIZE_W(SIZE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int beats    = 0;

    // Reference model: packet progress and pattern, updated once per rising edge
    bit           m_busy, m_sop, m_done, m_zero, m_ign;
    int           m_rem;
    logic [127:0] m_pat;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] lane_step(input logic [127:0] p);
        logic [127:0] r;
        int unsigned  l, fb;
        for (int n = 0; n < 4; n++) begin
            l  = p[32*n +: 32];
            fb = ((l >> 31) ^ (l >> 21) ^ (l >> 1) ^ l) & 1;
            r[32*n +: 32] = (l << 1) | fb;
        end
        return r;
    endfunction

    task automatic model_step(input bit rst, input bit sv, input logic [127:0] sd,
                              input bit zv, input int zd, input bit rdy);
        if (rst) begin
            m_busy = 0; m_sop = 0; m_done = 0; m_zero = 0; m_ign = 0; m_rem = 0; m_pat = '0;
        end else if (!m_busy) begin
            if (sv) m_pat = sd;
            if (zv && zd != 0) begin
                m_busy = 1; m_sop = 1; m_rem = zd; m_done = 0; m_zero = 0; m_ign = 0;
            end else if (zv) begin
                m_zero = 1; m_done = 0;
            end
        end else begin
            if (zv) m_ign = 1;
            if (rdy) begin
                m_pat = sv ? sd : lane_step(m_pat);
                m_sop = 0;
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit sv, input logic [127:0] sd,
                         input bit zv, input int zd, input bit rdy);
        reset              = rst;
        bus.asi_seed_valid = sv;
        bus.asi_seed_data  = sd;
        bus.asi_size_valid = zv;
        bus.asi_size_data  = SIZE_W'(zd);
        bus.aso_data_ready = rdy;
        if (bus.aso_data_valid && rdy && !rst) beats++;
        @(posedge clk);
        model_step(rst, sv, sd, zv, zd, rdy);
        @(negedge clk);
        chk("ctrl", {bus.aso_data_valid, bus.aso_data_startofpacket, bus.aso_data_endofpacket,
                     bus.aso_pktstatus_data},
            {m_busy, m_busy && m_sop, m_busy && (m_rem == 1), m_ign, m_zero, m_done, m_busy});
        chk("data", bus.aso_data_data, m_pat);
    endtask

    task automatic idle(input bit rdy);
        cycle(0, 0, '0, 0, 0, rdy);
    endtask

    logic [127:0] ones, s;

    initial begin
        reset = 1'b1;
        bus.asi_seed_valid = 0; bus.asi_seed_data = '0;
        bus.asi_size_valid = 0; bus.asi_size_data = '0;
        bus.aso_data_ready = 0;
        @(negedge clk);
        // Reset dominates simultaneous strobes
        cycle(1, 1, {4{32'hDEAD_BEEF}}, 1, 3, 1);
        chk("rst_status", bus.aso_pktstatus_data, 4'h0);
        chk("rst_valid", bus.aso_data_valid, 1'b0);

        ones = {4{32'h0000_0001}};
        cycle(0, 1, ones, 1, 3, 1);
        chk("b1_data", bus.aso_data_data, ones);
        chk("b1_sop", {bus.aso_data_startofpacket, bus.aso_data_endofpacket}, 2'b10);
        idle(1);
        chk("b2_data", bus.aso_data_data, {4{32'h0000_0003}});
        idle(1);
        chk("b3_data", bus.aso_data_data, {4{32'h0000_0006}});
        chk("b3_eop", {bus.aso_data_startofpacket, bus.aso_data_endofpacket}, 2'b01);
        idle(1);
        chk("p3_status", bus.aso_pktstatus_data, 4'h2);

        cycle(0, 0, '0, 1, 1, 1);
        chk("s1_status", bus.aso_pktstatus_data, 4'h1);
        chk("s1_soeop", {bus.aso_data_startofpacket, bus.aso_data_endofpacket}, 2'b11);
        idle(1);
        chk("s1_done", bus.aso_pktstatus_data, 4'h2);

        cycle(0, 0, '0, 1, 0, 1);
        chk("z_status", bus.aso_pktstatus_data, 4'h4);
        chk("z_valid", bus.aso_data_valid, 1'b0);

        // Stalled packet: ready pattern 1,0,0 repeating
        beats = 0;
        cycle(0, 1, {32'h1234_5678, 32'h0, 32'h8000_0001, 32'hFFFF_FFFF}, 1, 4, 0);
        for (int i = 0; i < 40 && bus.aso_data_valid; i++) idle((i % 3) == 0);
        chk("stall_drain", bus.aso_data_valid, 1'b0);
        chk("stall_beats", beats, 4);

        // Seed held high: every beat repeats the seed
        s = {32'hA5A5_0001, 32'h0BAD_F00D, 32'h1, 32'h7777_7777};
        beats = 0;
        cycle(0, 1, s, 1, 5, 1);
        for (int i = 0; i < 20 && bus.aso_data_valid; i++) begin
            chk("const_data", bus.aso_data_data, s);
            cycle(0, 1, s, 0, 0, 1);
        end
        chk("const_beats", beats, 5);

        // Start during RUN is ignored and flagged
        beats = 0;
        idle(1);
        cycle(0, 0, '0, 1, 6, 1);
        idle(1);
        cycle(0, 0, '0, 1, 2, 1);
        for (int i = 0; i < 20 && bus.aso_data_valid; i++) idle(1);
        chk("ign_beats", beats, 6);
        chk("ign_status", bus.aso_pktstatus_data, 4'hA);

        // Reset mid-packet
        cycle(0, 1, ones, 1, 9, 1);
        idle(1);
        cycle(1, 0, '0, 0, 0, 1);
        chk("abort_valid", bus.aso_data_valid, 1'b0);
        chk("abort_status", bus.aso_pktstatus_data, 4'h0);
        idle(1);
        chk("abort_idle", bus.aso_pktstatus_data, 4'h0);

        // Maximum length without wrap
        beats = 0;
        cycle(0, 1, ones, 1, (1 << SIZE_W) - 1, 1);
        for (int i = 0; i < 1000 && bus.aso_data_valid; i++) idle($urandom_range(0, 3) != 0);
        chk("max_drain", bus.aso_data_valid, 1'b0);
        chk("max_beats", beats, (1 << SIZE_W) - 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) s[127:96] = '0;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, s,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
